// File: rtl/tl_tracker_pkg.sv
// tl_tracker_pkg: shared types and defaults for the in-flight source tracker and its monitors
package tl_tracker_pkg;
  localparam int DEFAULT_SRC_W = 4;
  localparam int DEFAULT_DEPTH = 8;
  typedef logic [DEFAULT_SRC_W-1:0] src_t;
  typedef enum logic [1:0] {ERR_MISMATCH, ERR_UNDERFLOW, ERR_OVERFLOW} err_cause_t;
endpackage

// File: rtl/tl_src_fifo.sv
// tl_src_fifo: circular buffer of source IDs with occupancy count and full/empty flags
module tl_src_fifo #(
  parameter int SRC_W = 4,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [SRC_W-1:0] i_wdata,
  output logic [SRC_W-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [SRC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clock)
    if (i_push) r_mem[r_wr] <= i_wdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full  = r_cnt == CNT_W'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/tl_inflight_source_tracker.sv
// tl_inflight_source_tracker: in-order A->D source tracking with mismatch, underflow and overflow flags
module tl_inflight_source_tracker
  import tl_tracker_pkg::*;
#(
  parameter int SRC_W = DEFAULT_SRC_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             a_ready,
  input  logic [SRC_W-1:0] a_source,
  input  logic             d_valid,
  input  logic             d_ready,
  input  logic [SRC_W-1:0] d_source,
  input  logic             d_last,
  input  logic             d_bypass,
  output logic             expect_valid,
  output logic [SRC_W-1:0] expect_source,
  output logic [CNT_W-1:0] count,
  output logic             src_mismatch,
  output logic             underflow,
  output logic             overflow,
  output logic             err_sticky
);
  logic             w_track, w_pop, w_push, w_uf, w_of, w_full, w_empty, w_afire;
  logic [SRC_W-1:0] w_head;
  logic             r_uf, r_of, r_sticky;
  assign w_afire = a_valid & a_ready;
  assign w_track = d_valid & d_ready & ~d_bypass;
  assign w_pop   = w_track & d_last & ~w_empty;
  assign w_uf    = w_track & d_last & w_empty;
  // a pop in the same cycle frees the slot, so a push while full is still accepted
  assign w_of    = w_afire & w_full & ~w_pop;
  assign w_push  = w_afire & ~w_of;
  tl_src_fifo #(.SRC_W(SRC_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (a_source),
    .o_head  (w_head),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_uf     <= 1'b0;
      r_of     <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_uf     <= w_uf;
      r_of     <= w_of;
      r_sticky <= r_sticky | src_mismatch | w_uf | w_of;
    end
  assign src_mismatch  = w_track & (w_empty | (d_source != w_head));
  assign expect_valid  = ~w_empty;
  assign expect_source = w_empty ? '0 : w_head;
  assign underflow     = r_uf;
  assign overflow      = r_of;
  assign err_sticky    = r_sticky;
endmodule

// File: doc/tl_inflight_source_tracker.md
Name: tl_inflight_source_tracker

Overview:
- In-order tracker of outstanding request source IDs on a single TileLink-style A/D channel pair.
- Every accepted A request pushes its source ID; the last beat of every tracked D response pops one entry.
- Produces the expected response source, plus mismatch, underflow and overflow indications, for the channel assertion monitors.
- Sits beside the port it tracks as the request-side generator of the values those monitors compare.

Parameters:
- SRC_W, 4, width of source ID fields.
- DEPTH, 8, maximum outstanding requests; power of two, at least 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, not overridable.

Ports:
- clock  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- a_valid  input  1  A-channel request valid.
- a_ready  input  1  A-channel request ready; a_fire = a_valid & a_ready.
- a_source  input  SRC_W  source ID of the A request.
- d_valid  input  1  D-channel response valid.
- d_ready  input  1  D-channel response ready; d_fire = d_valid & d_ready.
- d_source  input  SRC_W  source ID of the D beat.
- d_last  input  1  current D beat is the final beat of its response.
- d_bypass  input  1  response is untracked (e.g. release ack); it neither pops nor checks.
- expect_valid  output  1  tracker is non-empty.
- expect_source  output  SRC_W  head entry source ID; 0 when empty.
- count  output  CNT_W  number of outstanding entries.
- src_mismatch  output  1  combinational; this cycle's D beat violates ordering.
- underflow  output  1  registered one-cycle pulse: a tracked last beat popped while empty.
- overflow  output  1  registered one-cycle pulse: a push was dropped because the tracker was full.
- err_sticky  output  1  latched OR of mismatch, underflow and overflow; clears only on reset.

Behaviour:
- Storage is a circular buffer of DEPTH x SRC_W with a write pointer, a read pointer and a count register.
- Reset values:
  - Pointers, count, underflow, overflow and err_sticky all 0.
  - expect_valid = 0 and expect_source = 0 during and after reset.
  - Storage contents are not reset.
- A tracked beat is d_fire & ~d_bypass.
- Check, every tracked beat (including non-last beats): src_mismatch = (count == 0) | (d_source != head).
  - src_mismatch is never asserted outside a tracked beat.
- Pop: a tracked beat with d_last = 1 and count != 0 advances rd_ptr by one.
- Push: a_fire with count != DEPTH writes a_source at wr_ptr and advances wr_ptr.
- Both pointers wrap from DEPTH-1 to 0 (natural binary wrap).
- Simultaneous events:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - This is legal when full: the pop frees the slot in the same cycle, so there is no overflow.
  - Push while empty with a tracked last beat in the same cycle: the push happens, the pop is refused, underflow pulses next cycle, and src_mismatch is 1 this cycle.
  - There is no same-cycle bypass from a_source to the head.
- Overflow: a_fire while count == DEPTH and no pop this cycle.
  - Entry dropped, pointers and count unchanged.
  - overflow = 1 for exactly one cycle after the event.
- Latency:
  - expect_valid, expect_source and count reflect a push/pop one cycle after the fire edge.
  - src_mismatch is same-cycle combinational from registered state and the D inputs.
  - underflow and overflow are 1-cycle registered pulses; err_sticky sets on the same edge as the pulse and, for mismatch, on the edge after the beat.
- Reset asserted mid-operation drops all outstanding entries immediately, with no pulses. The first cycle after deassertion behaves as empty.
- Under ifndef SYNTHESIS the block embeds no $fatal; reporting is the monitor's job.

Decomposition:
- Shared package tl_tracker_pkg holds:
  - typedef src_t (logic [SRC_W-1:0] for the default width);
  - localparam DEFAULT_DEPTH = 8;
  - an error-cause enum {ERR_MISMATCH, ERR_UNDERFLOW, ERR_OVERFLOW} for monitor reporting.
- One sub-module is natural: tl_src_fifo, the circular buffer with pointers, count and full/empty.
- The top level adds the check logic, the pulses and the sticky bit.

Test Plan:
1. Reset, then push sources 3, 5, 9 on consecutive cycles -> count = 3, expect_source = 3. Single-beat D with sources 3, 5, 9 -> src_mismatch = 0 throughout, count returns to 0, expect_valid = 0.
2. Push 2, then a 4-beat D response with source 2 and d_last on beat 4 only -> src_mismatch = 0 on all beats, pop occurs only after beat 4.
3. Push 7, then D source 6 with d_last = 1 -> src_mismatch = 1 that cycle, err_sticky = 1 next cycle, entry 7 popped, count = 0.
4. Fill 8 entries (sources 0..7), then push 15 -> overflow pulses one cycle, count stays 8. Next, push 15 while popping source 0 in the same cycle -> no overflow, count = 8, and after 8 pops the last expect_source = 15 (wrap verified).
5. Empty tracker, tracked D last beat -> src_mismatch = 1, underflow pulses, count stays 0. Same stimulus with d_bypass = 1 -> no flags raised.
6. With 4 entries outstanding, assert reset for 2 cycles mid-burst -> outputs clear asynchronously, no pulses, and err_sticky = 0 after release.
